// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
//
// Purpose:
//   Two-requester arbiter in front of a single-port data memory. Port 0 is the
//   core load/store unit, port 1 the debug/DMA loader. One access is granted
//   per cycle. The arbiter drives the memory write-enable, address and write
//   data, and returns registered read data with a one-cycle valid strobe.
//   Ties are broken round-robin by default.
//
// Build option:
//   DMEM_ARB_FIXED_PRIO_EN - when defined, port 0 always wins a tie and the
//                            round-robin history is not kept.
//
// Ports:
//   clk, rst                 clock (rising edge), synchronous active-high reset
//   req0/we0/addr0/wdata0    port 0 request, write enable, address, write data
//   ack0                     port 0 access performed this cycle (one-cycle pulse)
//   rvalid0/rdata0           port 0 read data strobe and registered read data
//   req1 ... rdata1          same for port 1
//   mem_we/mem_a/mem_wd      memory write enable, address, write data
//   mem_rd                   memory combinational read data
//   busy                     high while an access is in progress
// ---------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              ack0,
    output logic              rvalid0,
    output logic [DATA_W-1:0] rdata0,

    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata1,

    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_a,
    output logic [DATA_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_rd,

    output logic              busy
);

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic              gnt_q, gnt_d;
    logic [1:0]        ack_q, ack_d;
    logic [1:0]        rvalid_q, rvalid_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_a_q, mem_a_d;
    logic [DATA_W-1:0] mem_wd_q, mem_wd_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;

    logic [1:0]        req;
    logic              tie_win;

    assign req = {req1, req0};

`ifdef DMEM_ARB_FIXED_PRIO_EN
    assign tie_win = 1'b0;
`else
    // Port that was served most recently; reset to 1 so port 0 wins the
    // first tie.
    logic last_q, last_d;
    assign tie_win = ~last_q;
`endif

    // -----------------------------------------------------------------------
    // State and output registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            gnt_q    <= 1'b0;
            ack_q    <= '0;
            rvalid_q <= '0;
            mem_we_q <= 1'b0;
            mem_a_q  <= '0;
            mem_wd_q <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
`ifndef DMEM_ARB_FIXED_PRIO_EN
            last_q   <= 1'b1;
`endif
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            ack_q    <= ack_d;
            rvalid_q <= rvalid_d;
            mem_we_q <= mem_we_d;
            mem_a_q  <= mem_a_d;
            mem_wd_q <= mem_wd_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
`ifndef DMEM_ARB_FIXED_PRIO_EN
            last_q   <= last_d;
`endif
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
`ifndef DMEM_ARB_FIXED_PRIO_EN
        last_d  = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    state_d = ACC;
                    // With a single requester, req1 alone picks the port.
                    gnt_d   = (req0 && req1) ? tie_win : req1;
                end
            end
            ACC: begin
`ifndef DMEM_ARB_FIXED_PRIO_EN
                last_d = gnt_q;
`endif
                // The port just acked is masked; only the other port can
                // continue back-to-back.
                if (req[~gnt_q]) begin
                    gnt_d = ~gnt_q;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Output next-values: memory drive for the upcoming access, read capture
    // for the access finishing now.
    // -----------------------------------------------------------------------
    always_comb begin
        ack_d    = '0;
        rvalid_d = '0;
        mem_we_d = 1'b0;
        mem_a_d  = mem_a_q;
        mem_wd_d = mem_wd_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;

        if (state_q == ACC && !mem_we_q) begin
            rvalid_d[gnt_q] = 1'b1;
            if (gnt_q) begin
                rdata1_d = mem_rd;
            end else begin
                rdata0_d = mem_rd;
            end
        end

        if (state_d == ACC) begin
            ack_d[gnt_d] = 1'b1;
            mem_we_d     = gnt_d ? we1    : we0;
            mem_a_d      = gnt_d ? addr1  : addr0;
            mem_wd_d     = gnt_d ? wdata1 : wdata0;
        end
    end

    // Reset in the ACC cycle withdraws the ack so the requester keeps its
    // request instead of believing the dropped access completed.
    assign ack0    = ack_q[0] & ~rst;
    assign ack1    = ack_q[1] & ~rst;
    assign rvalid0 = rvalid_q[0];
    assign rvalid1 = rvalid_q[1];
    assign rdata0  = rdata0_q;
    assign rdata1  = rdata1_q;
    assign mem_we  = mem_we_q;
    assign mem_a   = mem_a_q;
    assign mem_wd  = mem_wd_q;
    assign busy    = (state_q == ACC);

endmodule

// File: tb/tb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Randomized and directed stimulus for dmem_arbiter against a transaction
// level reference model. A small memory array stands in for Data_Mem.
// Build option DMEM_ARB_FIXED_PRIO_EN selects the fixed-priority tie rule
// in the model to match the design build.
// ---------------------------------------------------------------------------
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [31:0] addr0 = '0, wdata0 = '0, addr1 = '0, wdata1 = '0;
    logic        ack0, rvalid0, ack1, rvalid1, mem_we, busy;
    logic [31:0] rdata0, rdata1, mem_a, mem_wd, mem_rd;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .ack0(ack0), .rvalid0(rvalid0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .ack1(ack1), .rvalid1(rvalid1), .rdata1(rdata1),
        .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd),
        .busy(busy)
    );

    // Data_Mem stand-in: combinational read, write on clock edge.
    logic [31:0] fix_mem [64];
    logic        fix_init = 1'b0;
    assign mem_rd = (mem_a < 32'd64) ? fix_mem[mem_a[5:0]] : '0;
    always @(posedge clk) begin
        if (!fix_init) begin
            for (int i = 0; i < 64; i++) fix_mem[i] <= '0;
            fix_init <= 1'b1;
        end else if (mem_we) begin
            fix_mem[mem_a[5:0]] <= mem_wd;
        end
    end

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wd;
    } txn_t;

    txn_t q0[$];
    txn_t q1[$];
    int   gap0 = 0, gap1 = 0;
    bit   rand_gap = 0;
    bit   rst_cmd = 1;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    logic [31:0] ref_mem [64];
    bit          m_acc = 0;
    int          m_port = 0;
    int          m_last = 1;
    logic        m_we = 0;
    logic [31:0] m_addr = '0, m_wd = '0;
    logic [1:0]  e_ack = '0, e_rv = '0;
    logic [31:0] e_rd0 = '0, e_rd1 = '0, e_ma = '0, e_mwd = '0;
    logic        e_mwe = 0, e_busy = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic push(input int p, input logic we, input logic [31:0] a, input logic [31:0] d);
        txn_t t;
        t.we = we; t.addr = a; t.wd = d;
        if (p == 0) q0.push_back(t); else q1.push_back(t);
    endtask

    // Advance the model by one clock edge using the inputs about to be sampled.
    task automatic model_next();
        int g;
        e_ack = '0;
        e_rv  = '0;
        if (m_acc && m_we) ref_mem[m_addr[5:0]] = m_wd;
        if (rst) begin
            m_acc = 0; m_last = 1;
            e_rd0 = '0; e_rd1 = '0; e_ma = '0; e_mwd = '0; e_mwe = 0; e_busy = 0;
        end else begin
            if (m_acc) begin
                if (!m_we) begin
                    e_rv[m_port] = 1'b1;
                    if (m_port == 1) e_rd1 = ref_mem[m_addr[5:0]];
                    else             e_rd0 = ref_mem[m_addr[5:0]];
                end
                m_last = m_port;
            end
            g = -1;
            if (m_acc) begin
                if (m_port == 0 && req1) g = 1;
                else if (m_port == 1 && req0) g = 0;
            end else if (req0 && req1) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
                g = 0;
`else
                g = 1 - m_last;
`endif
            end else if (req0) g = 0;
            else if (req1) g = 1;
            m_acc  = (g >= 0);
            e_busy = m_acc;
            e_mwe  = 0;
            if (m_acc) begin
                m_port = g;
                m_we   = (g == 1) ? we1    : we0;
                m_addr = (g == 1) ? addr1  : addr0;
                m_wd   = (g == 1) ? wdata1 : wdata0;
                e_ack[g] = 1'b1;
                e_mwe  = m_we;
                e_ma   = m_addr;
                e_mwd  = m_wd;
            end
        end
    endtask

    // One cycle: check outputs mid-cycle, update requesters, advance model.
    task automatic step();
        txn_t t;
        @(negedge clk);
        check_eq("ack0",    ack0,    e_ack[0]);
        check_eq("ack1",    ack1,    e_ack[1]);
        check_eq("rvalid0", rvalid0, e_rv[0]);
        check_eq("rvalid1", rvalid1, e_rv[1]);
        check_eq("rdata0",  rdata0,  e_rd0);
        check_eq("rdata1",  rdata1,  e_rd1);
        check_eq("mem_we",  mem_we,  e_mwe);
        check_eq("mem_a",   mem_a,   e_ma);
        check_eq("mem_wd",  mem_wd,  e_mwd);
        check_eq("busy",    busy,    e_busy);

        if (rst_cmd) begin
            rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
        end else begin
            rst = 1'b0;
            if (e_ack[0]) begin req0 = 1'b0; gap0 = rand_gap ? int'($urandom_range(0, 2)) : 0; end
            if (e_ack[1]) begin req1 = 1'b0; gap1 = rand_gap ? int'($urandom_range(0, 2)) : 0; end
            if (!req0) begin
                if (gap0 > 0) gap0--;
                else if (q0.size() > 0) begin
                    t = q0.pop_front();
                    req0 = 1'b1; we0 = t.we; addr0 = t.addr; wdata0 = t.wd;
                end
            end
            if (!req1) begin
                if (gap1 > 0) gap1--;
                else if (q1.size() > 0) begin
                    t = q1.pop_front();
                    req1 = 1'b1; we1 = t.we; addr1 = t.addr; wdata1 = t.wd;
                end
            end
        end
        if (rst) begin
            #1;
            check_eq("ack0_in_rst", ack0, 1'b0);
            check_eq("ack1_in_rst", ack1, 1'b0);
        end
        model_next();
    endtask

    task automatic drain(input int max_cyc);
        bit done = 0;
        for (int i = 0; i < max_cyc && !done; i++) begin
            step();
            if (q0.size() == 0 && q1.size() == 0 && !req0 && !req1 && !m_acc) begin
                step();
                done = 1;
            end
        end
        check_eq("drain", done, 1'b1);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) ref_mem[i] = '0;

        // Reset for two cycles, then idle.
        rst_cmd = 1;
        repeat (2) step();
        rst_cmd = 0;
        repeat (10) step();

        // Port 0 write then read back.
        push(0, 1'b1, 32'd10, 32'hDEADBEEF);
        drain(20);
        push(0, 1'b0, 32'd10, 32'h0);
        drain(20);
        check_eq("rd10", rdata0, 32'hDEADBEEF);

        // Simultaneous writes to the same address after reset.
        rst_cmd = 1;
        repeat (2) step();
        rst_cmd = 0;
        push(0, 1'b1, 32'd20, 32'h11111111);
        push(1, 1'b1, 32'd20, 32'hCAFEBABE);
        drain(20);
        push(0, 1'b0, 32'd20, 32'h0);
        drain(20);
        check_eq("rd20", rdata0, 32'hCAFEBABE);

        // Continuous reads on both ports.
        for (int i = 0; i < 8; i++) begin
            push(0, 1'b0, 32'($urandom_range(0, 63)), 32'h0);
            push(1, 1'b0, 32'($urandom_range(0, 63)), 32'h0);
        end
        drain(60);

        // Reset in the ACC cycle of a port 1 read.
        push(1, 1'b1, 32'd30, 32'h30303030);
        drain(20);
        push(1, 1'b0, 32'd30, 32'h0);
        step();
        rst_cmd = 1;
        step();
        rst_cmd = 0;
        step();
        check_eq("rst_rdata1", rdata1, 32'h0);
        check_eq("rst_rvalid1", rvalid1, 1'b0);
        push(0, 1'b0, 32'd30, 32'h0);
        push(1, 1'b0, 32'd20, 32'h0);
        drain(20);

        // Tie straight after a lone port 0 access.
        push(0, 1'b1, 32'd40, 32'h40404040);
        drain(20);
        push(0, 1'b0, 32'd40, 32'h0);
        push(1, 1'b0, 32'd10, 32'h0);
        drain(20);

        // Random traffic with random idle gaps between requests.
        rand_gap = 1;
        for (int i = 0; i < 60; i++) begin
            push(0, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 63)), $urandom());
            push(1, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 63)), $urandom());
        end
        drain(3000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter in front of the single-port data memory (`Data_Mem`: `clk`, `WE`, `A`, `WD`, `RD`; write on clock edge, `RD` combinational).
- Port 0 is the core load/store unit. Port 1 is the debug/DMA loader.
- Grants one memory access at a time, drives the memory control/address/write-data, and returns registered read data with a valid strobe.
- Round-robin fairness by default.

Parameters:
- `ADDR_W`, 32, address width of requests and memory port.
- `DATA_W`, 32, data width.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req0`  in  1  port 0 access request; held until `ack0`.
- `we0`  in  1  port 0 write enable (1 = write, 0 = read); stable while `req0`.
- `addr0`  in  `ADDR_W`  port 0 address; stable while `req0`.
- `wdata0`  in  `DATA_W`  port 0 write data; stable while `req0`.
- `ack0`  out  1  one-cycle pulse: port 0 access performed this cycle.
- `rvalid0`  out  1  one-cycle pulse: `rdata0` valid (reads only).
- `rdata0`  out  `DATA_W`  port 0 read data.
- `req1`, `we1`, `addr1`, `wdata1`, `ack1`, `rvalid1`, `rdata1`: same as port 0, for port 1.
- `mem_we`  out  1  to `Data_Mem` `WE`.
- `mem_a`  out  `ADDR_W`  to `Data_Mem` `A`.
- `mem_wd`  out  `DATA_W`  to `Data_Mem` `WD`.
- `mem_rd`  in  `DATA_W`  from `Data_Mem` `RD`.
- `busy`  out  1  high while in ACC.

Behaviour:
- Reset (`rst` high at a rising edge) forces:
  - state = IDLE, `last` = 1 (so port 0 wins the first tie);
  - all outputs 0: `ack*`, `rvalid*`, `rdata*`, `mem_we`, `mem_a`, `mem_wd`, `busy`.
- Reset dominates all other inputs.
- Reset during ACC drops the in-flight access: no ack and no rvalid, and `mem_we` is 0 from the cycle after reset is sampled.
- FSM states: IDLE, ACC. State register `gnt` (1 bit) records the granted port.
- IDLE:
  - if any `req`, pick a winner, latch `gnt`, go to ACC next cycle;
  - otherwise stay in IDLE.
  - Arbitration takes one cycle.
- ACC (exactly one cycle per access):
  - `mem_a` / `mem_wd` = granted port's `addr` / `wdata`;
  - `mem_we` = granted `we`;
  - `ack[gnt]` = 1; `last` <= `gnt`.
  - For a read, `mem_rd` is registered into `rdata[gnt]` and `rvalid[gnt]` pulses on the next cycle.
  - For a write, memory updates at the end of the ACC cycle and no `rvalid` is produced.
- Leaving ACC: the acked port's `req` is masked.
  - If the other port's `req` is high, stay in ACC and switch `gnt` to it (back-to-back, one access per cycle).
  - Otherwise return to IDLE.
  - A requester that re-raises `req` after its ack is re-arbitrated from IDLE.
- Round-robin: on simultaneous requests in IDLE, the port ≠ `last` wins.
- Single requester: latency from `req` rise to `ack` = 2 cycles (IDLE sample, ACC). Read data arrives 1 cycle after `ack`.
- Outside ACC:
  - `mem_we` = 0; `mem_a` and `mem_wd` hold their last values (no spurious writes).
  - `rdata*` holds its value until the next read completes on that port.
- Requester protocol violations (changing `addr`/`we`/`wdata` while `req` is high, or dropping `req` before `ack`) are undefined. A `req` drop seen in IDLE is simply not granted.

Optional Feature:
- Macro `DMEM_ARB_FIXED_PRIO_EN`.
- Defined: fixed priority, port 0 always wins a tie and `last` is ignored. On leaving ACC after serving port 1, a pending port 0 is granted next; after serving port 0, port 1 is granted only if `req0` is not re-raised, i.e. it is granted on the masked cycle.
- Undefined: round-robin as above.

Test Plan:
- Reset then idle: `rst` = 1 for 2 cycles → all outputs 0 and `busy` = 0. With no requests, `mem_we` stays 0 for 10 cycles.
- Port 0 write then read:
  - `req0`, `we0` = 1, `addr0` = 10, `wdata0` = `32'hDEADBEEF` → `ack0` 2 cycles after `req0` rises, with `mem_we` = 1 and `mem_a` = 10 in that cycle.
  - Then read `addr0` = 10 → `rvalid0` with `rdata0` = `32'hDEADBEEF`.
- Simultaneous requests after reset:
  - port 0 writes `32'h11111111` to 20; port 1 writes `32'hCAFEBABE` to 20;
  - → `ack0` cycle N, `ack1` cycle N+1 (back-to-back);
  - a subsequent read of 20 returns `32'hCAFEBABE`.
- Round-robin fairness: both ports hold continuous read requests for 8 grants → acks alternate 0,1,0,1,…; neither port gets two consecutive grants; `busy` stays 1.
- Reset mid-access: assert `rst` in the ACC cycle of a port 1 read of address 30 → no `rvalid1`, `rdata1` = 0, state IDLE, `mem_we` = 0; the next tie is won by port 0.
- `DMEM_ARB_FIXED_PRIO_EN` build:
  - both ports requesting continuously, port 0 re-raising `req0` the cycle after each `ack0` → port 1 is granted only on masked cycles, i.e. grants 0,1,0,1;
  - with `req0` held constantly high across all acks → port 0 wins every IDLE tie.
